// File: rtl/lsu_pkg.sv
// Shared encodings and lane helpers for the load/store unit memory controller.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } state_e;

  function automatic logic [31:0] lane_shl(input logic [31:0] data, input logic [1:0] lane);
    return data << {lane, 3'b000};
  endfunction

  function automatic logic [31:0] lane_shr(input logic [31:0] data, input logic [1:0] lane);
    return data >> {lane, 3'b000};
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] data, input size_e size,
                                              input logic is_unsigned);
    logic [31:0] r;
    r = data;
    case (size)
      SZ_B:    r = {{24{~is_unsigned & data[7]}}, data[7:0]};
      SZ_H:    r = {{16{~is_unsigned & data[15]}}, data[15:0]};
      default: r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: store mask and data shift, misalignment detection, load extract/extend.
module lsu_align
  import lsu_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  mask,
  output logic [31:0] wdata_sh,
  output logic        misaligned,
  output logic [31:0] load_data
);

  always_comb begin
    mask       = '0;
    misaligned = 1'b0;
    case (size)
      SZ_B: mask = 4'b0001 << lane;
      SZ_H: begin
        mask       = 4'b0011 << lane;
        misaligned = lane[0];
      end
      SZ_W: begin
        mask       = 4'b1111;
        misaligned = |lane;
      end
      default: misaligned = 1'b1;
    endcase
  end

  always_comb begin
    wdata_sh  = lane_shl(wdata, lane);
    load_data = load_extend(lane_shr(rdata, lane), size, is_unsigned);
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: accepts pipeline accesses, runs a ready/valid memory
// handshake with optional timeout, and returns extended load data or a trap.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  input  logic [4:0]        i_req_rd,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       o_rsp_rdata,
  output logic [4:0]        o_rsp_rd,
  output logic              o_rsp_trap,
  output logic              o_busy,
  output logic              o_mem_valid,
  input  logic              i_mem_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_ren,
  output logic              o_mem_wen,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_mask,
  input  logic              i_mem_rvalid,
  input  logic [31:0]       i_mem_rdata
);

  // A zero timeout still needs a one-bit counter to keep the RTL legal.
  localparam int unsigned CW = (CNT_W > 0) ? CNT_W : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic              we_q;
  size_e             size_q;
  logic              uns_q;
  logic [1:0]        lane_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        mask_q;
  logic [31:0]       wdata_q;
  logic [4:0]        rd_q;
  logic [31:0]       rdata_q;
  logic              trap_q;
  logic [CW-1:0]     cnt_q;

  size_e       a_size;
  logic [1:0]  a_lane;
  logic        a_uns;
  logic [3:0]  a_mask;
  logic [31:0] a_wdata;
  logic        a_misaligned;
  logic [31:0] a_load;
  logic        timed_out;

  // The single aligner sees the incoming request in IDLE and the held request otherwise.
  always_comb begin
    a_size    = (state_q == ST_IDLE) ? size_e'(i_req_size) : size_q;
    a_lane    = (state_q == ST_IDLE) ? i_req_addr[1:0]     : lane_q;
    a_uns     = (state_q == ST_IDLE) ? i_req_unsigned      : uns_q;
    timed_out = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);
  end

  lsu_align u_align (
    .size        (a_size),
    .lane        (a_lane),
    .is_unsigned (a_uns),
    .wdata       (i_req_wdata),
    .rdata       (i_mem_rdata),
    .mask        (a_mask),
    .wdata_sh    (a_wdata),
    .misaligned  (a_misaligned),
    .load_data   (a_load)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_req_valid) state_d = a_misaligned ? ST_RESP : ST_REQ;
      ST_REQ: begin
        if (i_mem_ready)    state_d = (we_q || i_mem_rvalid) ? ST_RESP : ST_WAIT;
        else if (timed_out) state_d = ST_RESP;
      end
      ST_WAIT: if (i_mem_rvalid || timed_out) state_d = ST_RESP;
      ST_RESP: if (i_rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      we_q    <= 1'b0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      lane_q  <= '0;
      addr_q  <= '0;
      mask_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      rdata_q <= '0;
      trap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (i_req_valid) begin
          we_q    <= i_req_we;
          size_q  <= size_e'(i_req_size);
          uns_q   <= i_req_unsigned;
          lane_q  <= i_req_addr[1:0];
          addr_q  <= {i_req_addr[ADDR_W-1:2], 2'b00};
          mask_q  <= a_mask;
          wdata_q <= a_wdata;
          rd_q    <= i_req_rd;
          rdata_q <= '0;
          trap_q  <= a_misaligned;
          cnt_q   <= '0;
        end
        ST_REQ: begin
          cnt_q <= cnt_q + CW'(1);
          if (i_mem_ready) begin
            if (!we_q && i_mem_rvalid) rdata_q <= a_load;
          end else if (timed_out) begin
            trap_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q + CW'(1);
          if (i_mem_rvalid)   rdata_q <= a_load;
          else if (timed_out) trap_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_req_ready = (state_q == ST_IDLE);
    o_busy      = (state_q != ST_IDLE);
    o_mem_valid = (state_q == ST_REQ);
    o_mem_ren   = (state_q == ST_REQ) && !we_q;
    o_mem_wen   = (state_q == ST_REQ) &&  we_q;
    o_mem_addr  = (state_q == ST_REQ) ? addr_q  : '0;
    o_mem_mask  = (state_q == ST_REQ) ? mask_q  : '0;
    o_mem_wdata = (state_q == ST_REQ) ? wdata_q : '0;
    o_rsp_valid = (state_q == ST_RESP);
    o_rsp_rdata = (state_q == ST_RESP) ? rdata_q : '0;
    o_rsp_rd    = (state_q == ST_RESP) ? rd_q    : '0;
    o_rsp_trap  = (state_q == ST_RESP) && trap_q;
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: three instances share stimulus with timeouts 256, 4 and 0.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we, req_unsigned, rsp_ready, mem_ready, mem_rvalid;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, mem_rdata;
  logic [4:0]  req_rd;

  logic        req_ready [3];
  logic        rsp_valid [3];
  logic [31:0] rsp_rdata [3];
  logic [4:0]  rsp_rd    [3];
  logic        rsp_trap  [3];
  logic        busy      [3];
  logic        mem_valid [3];
  logic [31:0] mem_addr  [3];
  logic        mem_ren   [3];
  logic        mem_wen   [3];
  logic [31:0] mem_wdata [3];
  logic [3:0]  mem_mask  [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    lsu_mem_ctrl #(
      .ADDR_W         (32),
      .TIMEOUT_CYCLES ((g == 0) ? 256 : (g == 1) ? 4 : 0)
    ) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_req_valid    (req_valid),
      .o_req_ready    (req_ready[g]),
      .i_req_we       (req_we),
      .i_req_size     (req_size),
      .i_req_unsigned (req_unsigned),
      .i_req_addr     (req_addr),
      .i_req_wdata    (req_wdata),
      .i_req_rd       (req_rd),
      .o_rsp_valid    (rsp_valid[g]),
      .i_rsp_ready    (rsp_ready),
      .o_rsp_rdata    (rsp_rdata[g]),
      .o_rsp_rd       (rsp_rd[g]),
      .o_rsp_trap     (rsp_trap[g]),
      .o_busy         (busy[g]),
      .o_mem_valid    (mem_valid[g]),
      .i_mem_ready    (mem_ready),
      .o_mem_addr     (mem_addr[g]),
      .o_mem_ren      (mem_ren[g]),
      .o_mem_wen      (mem_wen[g]),
      .o_mem_wdata    (mem_wdata[g]),
      .o_mem_mask     (mem_mask[g]),
      .i_mem_rvalid   (mem_rvalid),
      .i_mem_rdata    (mem_rdata)
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; req_rd = '0;
    rsp_ready = 1'b1; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    step; step;
    rst_n = 1'b1;
  endtask

  task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
    req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    req_valid = 1'b1;
    step;
    req_valid = 1'b0;
  endtask

  task automatic run_store(input string tag, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_addr,
                           input logic [3:0] exp_mask, input logic [31:0] exp_wdata);
    mem_ready = 1'b1;
    drive_req(1'b1, size, 1'b0, addr, wdata, 5'd5);
    @(negedge clk);
    check_eq({tag, "_mvalid"}, mem_valid[0], 1);
    check_eq({tag, "_addr"},   mem_addr[0],  exp_addr);
    check_eq({tag, "_mask"},   mem_mask[0],  exp_mask);
    check_eq({tag, "_wdata"},  mem_wdata[0], exp_wdata);
    check_eq({tag, "_wen"},    {mem_wen[0], mem_ren[0]}, 2'b10);
    check_eq({tag, "_rsp_early"}, rsp_valid[0], 0);
    step;
    @(negedge clk);
    check_eq({tag, "_rsp"},  {rsp_valid[0], rsp_trap[0], mem_valid[0]}, 3'b100);
    check_eq({tag, "_rdata"}, rsp_rdata[0], 0);
    check_eq({tag, "_rd"},    rsp_rd[0], 5);
    step;
    mem_ready = 1'b0;
  endtask

  task automatic run_load_fast(input string tag, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] rdata,
                               input logic [31:0] exp);
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = rdata;
    drive_req(1'b0, size, uns, addr, 32'h0, 5'd11);
    @(negedge clk);
    check_eq({tag, "_ren"}, {mem_valid[0], mem_ren[0], rsp_valid[0]}, 3'b110);
    step;
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    check_eq({tag, "_rsp"},   {rsp_valid[0], rsp_trap[0]}, 2'b10);
    check_eq({tag, "_rdata"}, rsp_rdata[0], exp);
    step;
  endtask

  task automatic run_trap(input string tag, input logic [1:0] size, input logic [31:0] addr);
    mem_ready = 1'b1;
    drive_req(1'b0, size, 1'b0, addr, 32'h0, 5'd2);
    @(negedge clk);
    check_eq({tag, "_rsp"},   {rsp_valid[0], rsp_trap[0], mem_valid[0]}, 3'b110);
    check_eq({tag, "_rdata"}, rsp_rdata[0], 0);
    step;
    @(negedge clk);
    check_eq({tag, "_idle"}, {mem_valid[0], req_ready[0]}, 2'b01);
    mem_ready = 1'b0;
  endtask

  initial begin
    int seen;
    do_reset;
    @(negedge clk);
    check_eq("rst_ready", req_ready[0], 1);
    check_eq("rst_outs", {busy[0], mem_valid[0], rsp_valid[0], mem_ren[0], mem_wen[0]}, 0);
    check_eq("rst_addr", mem_addr[0], 0);

    // Stores: lane shift and mask
    run_store("sb", 2'b00, 32'h0000_2003, 32'h0000_00AB, 32'h0000_2000, 4'b1000, 32'hAB00_0000);
    run_store("sh", 2'b01, 32'h0000_2002, 32'h1234_CDEF, 32'h0000_2000, 4'b1100, 32'hCDEF_0000);

    // lh with three cycles in WAIT before read data
    mem_ready = 1'b1;
    drive_req(1'b0, 2'b01, 1'b0, 32'h0000_1002, 32'h0, 5'd7);
    @(negedge clk);
    check_eq("lh_req", {mem_valid[0], mem_ren[0], mem_wen[0]}, 3'b110);
    check_eq("lh_addr", mem_addr[0], 32'h0000_1000);
    check_eq("lh_mask", mem_mask[0], 4'b1100);
    step;
    mem_ready = 1'b0;
    @(negedge clk);
    check_eq("lh_wait", {mem_valid[0], busy[0], rsp_valid[0]}, 3'b010);
    step; step;
    mem_rvalid = 1'b1; mem_rdata = 32'h8001_1234;
    step;
    mem_rvalid = 1'b0;
    @(negedge clk);
    check_eq("lh_rsp", {rsp_valid[0], rsp_trap[0]}, 2'b10);
    check_eq("lh_rdata", rsp_rdata[0], 32'hFFFF_8001);
    check_eq("lh_rd", rsp_rd[0], 7);
    step;

    run_load_fast("lhu", 2'b01, 1'b1, 32'h0000_1002, 32'h8001_1234, 32'h0000_8001);
    run_load_fast("lb",  2'b00, 1'b0, 32'h0000_3001, 32'h0000_F600, 32'hFFFF_FFF6);
    run_load_fast("lw",  2'b10, 1'b0, 32'h0000_4000, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    run_trap("lw_mis",  2'b10, 32'h0000_1006);
    run_trap("sz_ill",  2'b11, 32'h0000_1000);
    run_trap("lh_mis",  2'b01, 32'h0000_1001);

    // Response backpressure
    rsp_ready = 1'b0; mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    drive_req(1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0, 5'd9);
    step;
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_flags", {rsp_valid[0], rsp_trap[0], req_ready[0], busy[0]}, 4'b1001);
      check_eq("bp_rdata", rsp_rdata[0], 32'hDEAD_BEEF);
      check_eq("bp_rd", rsp_rd[0], 9);
      step;
    end
    rsp_ready = 1'b1;
    step;
    @(negedge clk);
    check_eq("bp_release", {req_ready[0], rsp_valid[0]}, 2'b10);

    // Timeout after four cycles in REQ
    do_reset;
    drive_req(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 5'd3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("to4_req", {mem_valid[1], rsp_valid[1]}, 2'b10);
      step;
    end
    @(negedge clk);
    check_eq("to4_trap", {mem_valid[1], rsp_valid[1], rsp_trap[1]}, 3'b011);
    check_eq("to4_rdata", rsp_rdata[1], 0);
    check_eq("to256_still", {mem_valid[0], rsp_valid[0]}, 2'b10);
    step;

    // Reset while waiting for read data, then a stray rvalid
    do_reset;
    mem_ready = 1'b1;
    drive_req(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0, 5'd4);
    step;
    mem_ready = 1'b0;
    @(negedge clk);
    check_eq("rw_wait", {busy[0], mem_valid[0]}, 2'b10);
    rst_n = 1'b0;
    step;
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    step;
    mem_rvalid = 1'b0;
    @(negedge clk);
    check_eq("rw_stray", {rsp_valid[0], req_ready[0], busy[0]}, 3'b010);
    step;
    @(negedge clk);
    check_eq("rw_quiet", {rsp_valid[0], req_ready[0]}, 2'b01);

    // Timeout disabled: no trap within 1000 cycles
    do_reset;
    drive_req(1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0, 5'd1);
    seen = 0;
    repeat (1000) begin
      @(negedge clk);
      if (rsp_valid[2]) seen++;
      step;
    end
    @(negedge clk);
    check_eq("to0_no_rsp", seen, 0);
    check_eq("to0_still_req", {mem_valid[2], busy[2]}, 2'b11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
